// File: rtl/sqrt_mag_sq_feed.sv
// rtl/sqrt_mag_sq_feed.sv - squared-magnitude feeder for the pipelined square-root block
module sqrt_mag_sq_feed #(
    parameter int DATA_BITS = 8,
    localparam int OUT_BITS = 2 * DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] x,
    input  logic [DATA_BITS-1:0] y,
    output logic                 busy,
    output logic                 start,
    output logic [OUT_BITS-1:0]  radicand
);

    localparam int CNT_W = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQ_X = 2'd1,
        SQ_Y = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [DATA_BITS-1:0] mag_x;
    logic [DATA_BITS-1:0] mag_y;
    logic [DATA_BITS-1:0] abs_x;
    logic [DATA_BITS-1:0] abs_y;
    logic [DATA_BITS-1:0] cur;
    logic [CNT_W-1:0]     bit_cnt;
    logic [OUT_BITS-1:0]  acc;
    logic [OUT_BITS-1:0]  partial;
    logic [OUT_BITS-1:0]  sum;
    logic                 last_bit;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Magnitudes of the inputs and one shift-add step shared by both squares.
    // The most negative input negates to 2^(DATA_BITS-1), which still fits unsigned.
    always_comb begin
        abs_x    = x[DATA_BITS-1] ? (~x + DATA_BITS'(1)) : x;
        abs_y    = y[DATA_BITS-1] ? (~y + DATA_BITS'(1)) : y;
        cur      = (state == SQ_Y) ? mag_y : mag_x;
        partial  = cur[bit_cnt] ? (OUT_BITS'(cur) << bit_cnt) : '0;
        sum      = acc + partial;
        last_bit = (bit_cnt == CNT_LAST);
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: each square takes exactly DATA_BITS edges, no early exit.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = SQ_X;
            SQ_X:    if (last_bit) state_next = SQ_Y;
            SQ_Y:    if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture magnitudes on accept, accumulate, publish sum with a start pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mag_x    <= '0;
            mag_y    <= '0;
            acc      <= '0;
            bit_cnt  <= '0;
            start    <= 1'b0;
            radicand <= '0;
        end else begin
            start <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mag_x   <= abs_x;
                        mag_y   <= abs_y;
                        acc     <= '0;
                        bit_cnt <= '0;
                    end
                end
                SQ_X, SQ_Y: begin
                    acc     <= sum;
                    bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
                    if ((state == SQ_Y) && last_bit) begin
                        radicand <= sum;
                        start    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_mag_sq_feed.sv
// tb/tb_sqrt_mag_sq_feed.sv - directed testbench for sqrt_mag_sq_feed
module tb_sqrt_mag_sq_feed;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        busy;
    logic        start;
    logic [15:0] radicand;

    int n_checks;
    int n_fail;
    int start_count;

    typedef struct {
        logic signed [7:0] xv;
        logic signed [7:0] yv;
        logic [15:0]       exp;
    } vec_t;

    vec_t vecs[8];

    sqrt_mag_sq_feed #(.DATA_BITS(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x        (x),
        .y        (y),
        .busy     (busy),
        .start    (start),
        .radicand (radicand)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (start === 1'b1) start_count++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Ticks until start is seen; lat = number of edges, -1 on timeout.
    // ready_bad is set if in_ready was seen high while waiting.
    task automatic wait_start(output int lat, output bit ready_bad);
        lat = -1;
        ready_bad = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (in_ready !== 1'b0) ready_bad = 1;
            if (start === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    // Accept one sample from IDLE and check latency, result, ready timing and pulse count.
    task automatic run_sample(input logic signed [7:0] xv, input logic signed [7:0] yv,
                              input logic [15:0] exp, input string name);
        int lat;
        bit rb;
        int sc0;
        sc0 = start_count;
        check({name, " ready_before"}, 32'(in_ready), 32'd1);
        x = xv;
        y = yv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        x = 8'h5a;
        y = 8'ha5;
        wait_start(lat, rb);
        check({name, " latency"}, lat, 32'd16);
        check({name, " ready_low"}, 32'(rb), 32'd0);
        check({name, " radicand"}, 32'(radicand), 32'(exp));
        tick();
        check({name, " ready_after"}, 32'(in_ready), 32'd1);
        check({name, " start_after"}, 32'(start), 32'd0);
        check({name, " hold"}, 32'(radicand), 32'(exp));
        check({name, " one_pulse"}, start_count - sc0, 32'd1);
    endtask

    initial begin
        int lat;
        bit rb;
        int sc0;
        logic signed [7:0] rx;
        logic signed [7:0] ry;
        int ex;

        n_checks = 0;
        n_fail = 0;
        start_count = 0;

        vecs[0] = '{ 8'sd3,    8'sd4,    16'd25};
        vecs[1] = '{-8'sd128, -8'sd128,  16'd32768};
        vecs[2] = '{ 8'sd127, -8'sd127,  16'd32258};
        vecs[3] = '{ 8'sd0,    8'sd0,    16'd0};
        vecs[4] = '{-8'sd128,  8'sd127,  16'd32513};
        vecs[5] = '{ 8'sd1,   -8'sd1,    16'd2};
        vecs[6] = '{-8'sd7,    8'sd24,   16'd625};
        vecs[7] = '{ 8'sd127,  8'sd127,  16'd32258};

        reset_n = 1'b0;
        in_valid = 1'b0;
        x = '0;
        y = '0;
        #2;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset start", 32'(start), 32'd0);
        check("reset radicand", 32'(radicand), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();

        // Table of directed vectors
        for (int i = 0; i < 8; i++) begin
            run_sample(vecs[i].xv, vecs[i].yv, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Back-to-back with in_valid held high
        sc0 = start_count;
        x = 8'hff;
        y = 8'h00;
        in_valid = 1'b1;
        tick();
        x = 8'h00;
        wait_start(lat, rb);
        check("b2b first latency", lat, 32'd16);
        check("b2b first radicand", 32'(radicand), 32'd1);
        tick();
        check("b2b idle at +17", 32'(busy), 32'd0);
        tick();
        check("b2b second accept at +18", 32'(busy), 32'd1);
        in_valid = 1'b0;
        wait_start(lat, rb);
        check("b2b second latency", lat, 32'd16);
        check("b2b second radicand", 32'(radicand), 32'd0);
        tick();
        check("b2b pulses", start_count - sc0, 32'd2);

        // Input changes and in_valid pulse during SQ_X are ignored
        sc0 = start_count;
        x = 8'sd127;
        y = -8'sd127;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        x = 8'd5;
        y = 8'd5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_start(lat, rb);
        check("midx latency", lat, 32'd12);
        check("midx radicand", 32'(radicand), 32'd32258);
        repeat (4) tick();
        check("midx pulses", start_count - sc0, 32'd1);
        check("midx idle", 32'(busy), 32'd0);

        // Asynchronous reset mid-SQ_Y
        sc0 = start_count;
        x = 8'd9;
        y = 8'd9;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        check("midy busy before reset", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midy reset start", 32'(start), 32'd0);
        check("midy reset busy", 32'(busy), 32'd0);
        check("midy reset radicand", 32'(radicand), 32'd0);
        check("midy reset in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        repeat (25) tick();
        check("midy no pulse", start_count - sc0, 32'd0);
        run_sample(8'sd5, 8'sd12, 16'd169, "post reset");

        // Asynchronous reset during DONE drops start at once
        x = 8'd2;
        y = 8'd2;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_start(lat, rb);
        check("done start seen", 32'(start), 32'd1);
        reset_n = 1'b0;
        #1;
        check("done reset start", 32'(start), 32'd0);
        check("done reset radicand", 32'(radicand), 32'd0);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        tick();

        // Random samples against arithmetic model
        for (int i = 0; i < 20; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            ex = int'(rx) * int'(rx) + int'(ry) * int'(ry);
            run_sample(rx, ry, 16'(ex), $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
